// File: rtl/inst_encoder.sv
// inst_encoder: RV32I instruction word encoder with a 2-entry output FIFO.
// A request is encoded combinationally and written into the FIFO when accepted.
// The FIFO stores the encoded word and its error flag together.
//
// Handshake rule for both ports: a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready depends only on FIFO occupancy, so it
// never depends on in_valid in the same cycle. out_valid depends only on
// occupancy, so it never depends on out_ready in the same cycle.
module inst_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst_code,
    output logic        err,
    output logic [15:0] enc_count
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [31:0] w_code;
    logic        w_err;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_imm12_ok;
    logic        w_imm13_ok;
    logic        w_imm21_ok;

    logic [31:0] r_mem_code [2];
    logic        r_mem_err  [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [15:0] r_enc_count;

    // The upper immediate bits must be pure sign extension to fit each format.
    assign w_imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign w_imm13_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign w_imm21_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    // Pick the format from the opcode and pack fields; illegal requests become zero with err.
    always_comb begin
        w_code = 32'h0000_0000;
        w_err  = 1'b0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR: begin
                w_code = {imm[11:0], rs1, funct3, rd, opcode};
                w_err  = ~w_imm12_ok;
            end
            OP_STORE: begin
                w_code = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_err  = ~w_imm12_ok;
            end
            OP_BRANCH: begin
                w_code = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_err  = ~w_imm13_ok;
            end
            OP_JAL: begin
                w_code = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_err  = ~w_imm21_ok;
            end
            OP_LUI: begin
                w_code = {imm[31:12], rd, opcode};
                w_err  = |imm[11:0];
            end
            default: begin
                w_code = 32'h0000_0000;
                w_err  = 1'b1;
            end
        endcase
        if (w_err) begin
            w_code = 32'h0000_0000;
        end
    end

    // A full FIFO accepts nothing, even when a pop frees a slot at the same edge.
    assign w_full    = (r_count == 2'd2);
    assign in_ready  = ~w_full;
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid & ~w_full;
    assign w_pop     = out_valid & out_ready;

    // Head entry is masked when empty so the outputs read zero after reset.
    assign inst_code = out_valid ? r_mem_code[r_rd_ptr] : 32'h0000_0000;
    assign err       = out_valid ? r_mem_err[r_rd_ptr]  : 1'b0;
    assign enc_count = r_enc_count;

    // FIFO storage write; contents only matter once occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem_code[r_wr_ptr] <= w_code;
            r_mem_err[r_wr_ptr]  <= w_err;
        end
    end

    // Pointers, occupancy and the delivered-word counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_enc_count <= 16'h0000;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (!r_mem_err[r_rd_ptr]) begin
                    r_enc_count <= r_enc_count + 16'h0001;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder with hand-computed expected words.
module tb_inst_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_code;
    logic        err;
    logic [15:0] enc_count;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_cnt;

    inst_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_code (inst_code),
        .err       (err),
        .enc_count (enc_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
        opcode = op;
        rd     = d;
        rs1    = s1;
        rs2    = s2;
        funct3 = f3;
        imm    = im;
    endtask

    // Push one request with the output stalled, check the head, then drain it.
    task automatic send_one(input string tag, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [31:0] im, input logic [31:0] exp_code, input logic exp_err);
        out_ready = 1'b0;
        drive(op, d, s1, s2, f3, im);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_code"}, inst_code, exp_code);
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        if (!exp_err) exp_cnt = exp_cnt + 16'd1;
        check({tag, "_cnt"}, {16'b0, enc_count}, {16'b0, exp_cnt});
        check({tag, "_empty"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        exp_cnt   = 16'd0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        step();
        step();
        reset = 1'b0;

        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_inst_code", inst_code, 32'h0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_enc_count", {16'b0, enc_count}, 32'd0);

        // Encoding of each format, good and bad immediates
        send_one("itype", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 1'b0);
        send_one("utype", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0);
        send_one("stype", 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020A423, 1'b0);
        send_one("btype", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
        send_one("jtype", 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h001000EF, 1'b0);
        send_one("i_err", 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0, 1'b1);
        send_one("b_err", 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0, 1'b1);
        send_one("r_err", 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 32'h0, 1'b1);
        send_one("u_err", 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345001, 32'h0, 1'b1);

        // Backpressure: three requests against a stalled output
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        step();
        check("bp_ready_1", {31'b0, in_ready}, 32'd1);
        drive(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000);
        step();
        check("bp_ready_2", {31'b0, in_ready}, 32'd0);
        check("bp_head_2", inst_code, 32'h00500093);
        drive(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8);
        step();
        check("bp_ready_3", {31'b0, in_ready}, 32'd0);
        check("bp_head_3", inst_code, 32'h00500093);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_order_2", inst_code, 32'h123452B7);
        check("bp_valid_2", {31'b0, out_valid}, 32'd1);
        step();
        exp_cnt = exp_cnt + 16'd2;
        check("bp_drained", {31'b0, out_valid}, 32'd0);
        check("bp_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});
        out_ready = 1'b0;

        // Simultaneous push and pop at occupancy 1
        in_valid = 1'b1;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        step();
        drive(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("pp_valid", {31'b0, out_valid}, 32'd1);
        check("pp_head", inst_code, 32'h001000EF);
        check("pp_ready", {31'b0, in_ready}, 32'd1);
        step();
        exp_cnt = exp_cnt + 16'd2;
        check("pp_drained", {31'b0, out_valid}, 32'd0);
        check("pp_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});
        out_ready = 1'b0;

        // Pop on empty must not underflow
        out_ready = 1'b1;
        step();
        step();
        check("empty_pop_valid", {31'b0, out_valid}, 32'd0);
        check("empty_pop_ready", {31'b0, in_ready}, 32'd1);
        check("empty_pop_cnt", {16'b0, enc_count}, {16'b0, exp_cnt});
        out_ready = 1'b0;

        // Reset with two buffered entries and a request in the reset cycle
        in_valid = 1'b1;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        step();
        step();
        check("pre_rst_full", {31'b0, in_ready}, 32'd0);
        reset     = 1'b1;
        out_ready = 1'b1;
        step();
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 16'd0;
        check("mid_rst_cnt", {16'b0, enc_count}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        step();
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_cnt", {16'b0, enc_count}, 32'd0);

        // Stream good words until the counter wraps
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
        for (int i = 0; i < 65536; i++) begin
            step();
        end
        check("wrap_ffff", {16'b0, enc_count}, 32'h0000FFFF);
        check("wrap_head", inst_code, 32'h00500093);
        in_valid = 1'b0;
        step();
        check("wrap_zero", {16'b0, enc_count}, 32'h00000000);
        check("wrap_empty", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
